spi_sclk_engine: RTL and testbench

Parametrised SPI master clock engine. It generates the SCLK, chip-select and per-bit shift/sample strobes for one framed transfer from a single system clock. CPOL/CPHA are runtime selectable, SCLK frequency comes from a programmable divider, and word length is programmable. It sits between the register interface and the SPI shift register datapath, and drives that datapath's launch/capture enables. It replaces the two-phase external-clock scheme.

---
 rtl/spi_sclk_engine.sv | 206 ++++++++++++++++++++
 tb/tb_spi_sclk_engine.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sclk_engine.sv
// SPI master clock engine: SCLK, chip select and per-bit launch/capture strobes for one framed transfer.
// Optional chip-select hold between words is enabled by defining SPI_SCLK_CS_HOLD_EN.
module spi_sclk_engine #(
  parameter int DIV_WIDTH = 8,
  parameter int MAX_BITS  = 32,
  parameter int BW        = $clog2(MAX_BITS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_cpol,
  input  logic                 cfg_cpha,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic [BW-1:0]        cfg_nbits,
`ifdef SPI_SCLK_CS_HOLD_EN
  input  logic                 cs_hold,
`endif
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 sclk,
  output logic                 cs_n,
  output logic                 shift_en,
  output logic                 sample_en,
  output logic [BW-1:0]        bit_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_RUN,
    S_LAG
`ifdef SPI_SCLK_CS_HOLD_EN
    , S_HOLD
`endif
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [BW:0]          edge_q, edge_d;
  logic                 cpol_q, cpol_d;
  logic                 cpha_q, cpha_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [BW-1:0]        nbits_q, nbits_d;
`ifdef SPI_SCLK_CS_HOLD_EN
  logic                 hold_q, hold_d;
`endif

  logic          sclk_d, cs_n_d, busy_d, done_d, shift_d, sample_d;
  logic [BW-1:0] bit_idx_d;
  logic          accept;
  logic          expire;
  logic          leading;
  logic          last_edge;

  // edge_q counts edges already produced, so it never has to hold 2N itself
  assign expire    = (cnt_q == '0);
  assign leading   = ~edge_q[0];
  assign last_edge = (edge_q == {nbits_q, 1'b1});

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    edge_d    = edge_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    div_d     = div_q;
    nbits_d   = nbits_q;
`ifdef SPI_SCLK_CS_HOLD_EN
    hold_d    = hold_q;
`endif
    sclk_d    = sclk;
    cs_n_d    = cs_n;
    busy_d    = busy;
    done_d    = 1'b0;
    shift_d   = 1'b0;
    sample_d  = 1'b0;
    bit_idx_d = bit_idx;
    accept    = 1'b0;

    case (state_q)
      S_IDLE: begin
        sclk_d = cfg_cpol;
        cs_n_d = 1'b1;
        busy_d = 1'b0;
        accept = start;
      end

      S_LEAD, S_RUN: begin
        if (expire) begin
          sclk_d = ~sclk;
          cnt_d  = div_q;
          edge_d = edge_q + 1'b1;
          state_d = S_RUN;
          if (!cpha_q) begin
            sample_d = leading;
            shift_d  = ~leading & ~last_edge;
          end else begin
            shift_d  = leading;
            sample_d = ~leading;
          end
          // with CPHA=1 the launch on edge 1 is the first bit, so it keeps N-1
          if (shift_d && !(cpha_q && edge_q == '0) && bit_idx != '0)
            bit_idx_d = bit_idx - 1'b1;
          if (last_edge) begin
            edge_d  = '0;
            state_d = S_LAG;
`ifdef SPI_SCLK_CS_HOLD_EN
            if (hold_q) begin
              state_d = S_HOLD;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
`endif
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_LAG: begin
        if (expire) begin
          state_d = S_IDLE;
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          sclk_d  = cpol_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

`ifdef SPI_SCLK_CS_HOLD_EN
      S_HOLD: begin
        cs_n_d = 1'b0;
        busy_d = 1'b0;
        accept = start;
      end
`endif

      default: begin
        state_d = S_IDLE;
        cs_n_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    if (accept) begin
      cpol_d    = cfg_cpol;
      cpha_d    = cfg_cpha;
      div_d     = cfg_div;
      nbits_d   = cfg_nbits;
`ifdef SPI_SCLK_CS_HOLD_EN
      hold_d    = cs_hold;
`endif
      state_d   = S_LEAD;
      cnt_d     = cfg_div;
      edge_d    = '0;
      sclk_d    = cfg_cpol;
      cs_n_d    = 1'b0;
      busy_d    = 1'b1;
      bit_idx_d = cfg_nbits;
      shift_d   = ~cfg_cpha;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      edge_q    <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      div_q     <= '0;
      nbits_q   <= '0;
`ifdef SPI_SCLK_CS_HOLD_EN
      hold_q    <= 1'b0;
`endif
      sclk      <= 1'b0;
      cs_n      <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      shift_en  <= 1'b0;
      sample_en <= 1'b0;
      bit_idx   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      edge_q    <= edge_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      div_q     <= div_d;
      nbits_q   <= nbits_d;
`ifdef SPI_SCLK_CS_HOLD_EN
      hold_q    <= hold_d;
`endif
      sclk      <= sclk_d;
      cs_n      <= cs_n_d;
      busy      <= busy_d;
      done      <= done_d;
      shift_en  <= shift_d;
      sample_en <= sample_d;
      bit_idx   <= bit_idx_d;
    end
  end

endmodule

// File: tb/tb_spi_sclk_engine.sv
// Directed self-checking bench for spi_sclk_engine; the CS hold scenario runs when SPI_SCLK_CS_HOLD_EN is defined.
module tb_spi_sclk_engine;

  localparam int DIV_WIDTH = 8;
  localparam int MAX_BITS  = 32;
  localparam int BW        = 5;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 cfg_cpol = 1'b0;
  logic                 cfg_cpha = 1'b0;
  logic [DIV_WIDTH-1:0] cfg_div = '0;
  logic [BW-1:0]        cfg_nbits = '0;
  logic                 start = 1'b0;
`ifdef SPI_SCLK_CS_HOLD_EN
  logic                 cs_hold = 1'b0;
`endif
  logic                 busy, done, sclk, cs_n, shift_en, sample_en;
  logic [BW-1:0]        bit_idx;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spi_sclk_engine #(
    .DIV_WIDTH(DIV_WIDTH),
    .MAX_BITS (MAX_BITS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_cpol (cfg_cpol),
    .cfg_cpha (cfg_cpha),
    .cfg_div  (cfg_div),
    .cfg_nbits(cfg_nbits),
`ifdef SPI_SCLK_CS_HOLD_EN
    .cs_hold  (cs_hold),
`endif
    .start    (start),
    .busy     (busy),
    .done     (done),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .shift_en (shift_en),
    .sample_en(sample_en),
    .bit_idx  (bit_idx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Per-cycle observer, sampling mid-cycle; statistics clear while mon_en is low
  logic mon_en = 1'b0;
  logic mon_cpol = 1'b0;
  logic prev_sclk, seen_low, ed, ld;
  int t, n_edge, first_edge_t, last_edge_t, n_cs_low, n_busy, n_done, done_t;
  int n_sl, n_st, n_sn, n_hl, n_ht, n_hn, n_shift, first_idx, last_idx, n_idx_bad;
  int gap_run, n_gaps, gap_max;

  always @(negedge clk) begin
    if (!mon_en) begin
      t = 0; n_edge = 0; first_edge_t = 0; last_edge_t = 0; n_cs_low = 0; n_busy = 0;
      n_done = 0; done_t = 0; n_sl = 0; n_st = 0; n_sn = 0; n_hl = 0; n_ht = 0; n_hn = 0;
      n_shift = 0; first_idx = -1; last_idx = -1; n_idx_bad = 0;
      gap_run = 0; n_gaps = 0; gap_max = 0; seen_low = 1'b0;
      prev_sclk = sclk;
    end else begin
      t++;
      ed = (sclk !== prev_sclk);
      ld = ed && (sclk !== mon_cpol);
      prev_sclk = sclk;
      if (ed) begin
        n_edge++;
        if (first_edge_t == 0) first_edge_t = t;
        last_edge_t = t;
      end
      if (cs_n === 1'b0) n_cs_low++;
      if (busy === 1'b1) n_busy++;
      if (done === 1'b1) begin
        n_done++;
        if (done_t == 0) done_t = t;
      end
      if (sample_en === 1'b1) begin
        if (!ed) n_sn++;
        else if (ld) n_sl++;
        else n_st++;
      end
      if (shift_en === 1'b1) begin
        if (!ed) n_hn++;
        else if (ld) n_hl++;
        else n_ht++;
        if (n_shift == 0) first_idx = int'(bit_idx);
        else if (int'(bit_idx) != last_idx - 1) n_idx_bad++;
        last_idx = int'(bit_idx);
        n_shift++;
      end
      if (cs_n === 1'b0) begin
        if (gap_run > 0) begin
          n_gaps++;
          if (gap_run > gap_max) gap_max = gap_run;
        end
        gap_run = 0;
        seen_low = 1'b1;
      end else if (seen_low) begin
        gap_run++;
      end
    end
  end

  task automatic xfer(input string tag, input logic cpol, input logic cpha, input int div,
                      input int nbits, input int e_busy, input int e_edges, input int e_sl,
                      input int e_st, input int e_hl, input int e_ht, input int e_hn,
                      input int e_done_t, input int e_first, input int e_last,
                      input int e_fidx, input int e_lidx);
    @(negedge clk); #1;
    cfg_cpol = cpol; cfg_cpha = cpha; cfg_div = div[7:0]; cfg_nbits = nbits[4:0];
    mon_cpol = cpol;
    @(negedge clk); #1;
    check({tag, " idle sclk"}, sclk, cpol);
    start = 1'b1; mon_en = 1'b1;
    @(negedge clk); #1;
    // scramble live config: the transfer must run on the latched copy
    start = 1'b0;
    cfg_cpol = ~cpol; cfg_cpha = ~cpha; cfg_div = ~div[7:0]; cfg_nbits = ~nbits[4:0];
    for (int i = 0; i < 400 && n_done == 0; i++) begin
      @(negedge clk); #1;
    end
    cfg_cpol = cpol; cfg_cpha = cpha; cfg_div = div[7:0]; cfg_nbits = nbits[4:0];
    repeat (2) begin @(negedge clk); #1; end
    check({tag, " idle sclk after"}, sclk, cpol);
    check({tag, " cs_n after"}, cs_n, 1);
    check({tag, " done count"}, n_done, 1);
    check({tag, " done cycle"}, done_t, e_done_t);
    check({tag, " busy cycles"}, n_busy, e_busy);
    check({tag, " cs_n low cycles"}, n_cs_low, e_busy);
    check({tag, " sclk edges"}, n_edge, e_edges);
    check({tag, " first edge cycle"}, first_edge_t, e_first);
    check({tag, " last edge cycle"}, last_edge_t, e_last);
    check({tag, " sample on lead"}, n_sl, e_sl);
    check({tag, " sample on trail"}, n_st, e_st);
    check({tag, " sample no edge"}, n_sn, 0);
    check({tag, " shift on lead"}, n_hl, e_hl);
    check({tag, " shift on trail"}, n_ht, e_ht);
    check({tag, " shift no edge"}, n_hn, e_hn);
    check({tag, " first bit_idx"}, first_idx, e_fidx);
    check({tag, " last bit_idx"}, last_idx, e_lidx);
    check({tag, " bit_idx step"}, n_idx_bad, 0);
    mon_en = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // reset state, with cfg_cpol=1 to show reset wins over the idle level
    cfg_cpol = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst sclk", sclk, 0);
    check("rst cs_n", cs_n, 1);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst shift_en", shift_en, 0);
    check("rst sample_en", sample_en, 0);
    check("rst bit_idx", bit_idx, 0);
    rst = 1'b0; cfg_cpol = 1'b0;

    // tag cpol cpha div nbits | busy edges sl st hl ht hn done first last fidx lidx
    xfer("m0 d0 n8",  1'b0, 1'b0, 0, 7,   17, 16,  8,  0,  0,  7, 1,  18, 2,  17,  7, 0);
    xfer("m3 d3 n16", 1'b1, 1'b1, 3, 15, 132, 32,  0, 16, 16,  0, 0, 133, 5, 129, 15, 0);
    xfer("m2 d0 n1",  1'b1, 1'b0, 0, 0,    3,  2,  1,  0,  0,  0, 1,   4, 2,   3,  0, 0);
    xfer("m1 d0 n32", 1'b0, 1'b1, 0, 31,  65, 64,  0, 32, 32,  0, 0,  66, 2,  65, 31, 0);

    // back-to-back: start held high, mode 1, N=4, H=2
    @(negedge clk); #1;
    cfg_cpol = 1'b0; cfg_cpha = 1'b1; cfg_div = 8'd1; cfg_nbits = 5'd3; mon_cpol = 1'b0;
    @(negedge clk); #1;
    start = 1'b1; mon_en = 1'b1;
    repeat (60) @(negedge clk);
    #1;
    start = 1'b0;
    check("b2b done count", n_done, 3);
    check("b2b first done cycle", done_t, 19);
    check("b2b cs_n gaps", n_gaps, 3);
    check("b2b longest gap", gap_max, 1);
    check("b2b busy cycles", n_busy, 57);
    check("b2b cs_n low cycles", n_cs_low, 57);
    check("b2b sclk edges", n_edge, 25);
    check("b2b sample on trail", n_st, 12);
    check("b2b shift on lead", n_hl, 13);
    mon_en = 1'b0;
    for (int i = 0; i < 100 && busy === 1'b1; i++) begin
      @(negedge clk); #1;
    end
    check("b2b drain", busy, 0);

    // reset on edge 5 of an 8-bit mode-0 transfer, H=2
    @(negedge clk); #1;
    cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_div = 8'd1; cfg_nbits = 5'd7; mon_cpol = 1'b0;
    @(negedge clk); #1;
    start = 1'b1; mon_en = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("mid edges before rst", n_edge, 5);
    check("mid sclk before rst", sclk, 1);
    check("mid bit_idx before rst", bit_idx, 5);
    rst = 1'b1; cfg_cpol = 1'b1;
    @(negedge clk); #1;
    check("mid rst cs_n", cs_n, 1);
    check("mid rst busy", busy, 0);
    check("mid rst sclk", sclk, 0);
    check("mid rst done", done, 0);
    check("mid rst shift_en", shift_en, 0);
    check("mid rst bit_idx", bit_idx, 0);
    rst = 1'b0;
    @(negedge clk); #1;
    check("post rst sclk follows cpol", sclk, 1);
    cfg_cpol = 1'b0;
    repeat (4) begin @(negedge clk); #1; end
    check("post rst no done", n_done, 0);
    check("post rst sclk idle", sclk, 0);
    mon_en = 1'b0;
    xfer("after rst", 1'b0, 1'b0, 1, 7,   34, 16,  8,  0,  0,  7, 1,  35, 3,  33,  7, 0);

`ifdef SPI_SCLK_CS_HOLD_EN
    // two 8-bit words chained with cs_hold=1 then 0, mode 0, H=1
    @(negedge clk); #1;
    cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_div = 8'd0; cfg_nbits = 5'd7; mon_cpol = 1'b0;
    cs_hold = 1'b1;
    @(negedge clk); #1;
    start = 1'b1; mon_en = 1'b1;
    @(negedge clk); #1;
    cs_hold = 1'b0;
    for (int i = 0; i < 100 && n_done == 0; i++) begin
      @(negedge clk); #1;
    end
    check("hold first done cycle", done_t, 17);
    check("hold cs_n low in hold", cs_n, 0);
    check("hold busy in hold", busy, 0);
    @(negedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 100 && n_done < 2; i++) begin
      @(negedge clk); #1;
    end
    repeat (2) begin @(negedge clk); #1; end
    check("hold done count", n_done, 2);
    check("hold cs_n low cycles", n_cs_low, 34);
    check("hold cs_n gaps", n_gaps, 0);
    check("hold sclk edges", n_edge, 32);
    check("hold busy cycles", n_busy, 33);
    check("hold cs_n after", cs_n, 1);
    mon_en = 1'b0;
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
